// File: rtl/jpu_rf_pkg.sv
// Shared constants and FSM encoding for the reg16_8 access arbiter.
package jpu_rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

endpackage

// File: rtl/reg16_8_arbiter_if.sv
// Requester, grant and register-file signals shared by the arbiter and its neighbours.
interface reg16_8_arbiter_if #(
  parameter int DATA_W = jpu_rf_pkg::DATA_W,
  parameter int ADDR_W = jpu_rf_pkg::ADDR_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              rf_enable_write;
  logic              rf_enable_read;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;

  // Pipeline-stage side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, rf_data_out,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           rf_enable_write, rf_enable_read, rf_addr, rf_data_in
  );

  // Register-file side.
  modport rf (
    input  rf_enable_write, rf_enable_read, rf_addr, rf_data_in,
    output rf_data_out
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer toggles on every update strobe.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] win
);

  logic ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    win = 2'b00;
    if (req0 && req1) begin
      win = ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/reg16_8_arbiter.sv
// Round-robin arbiter serialising two requesters onto the single-port reg16_8.
//   state  | meaning
//   IDLE   | sample requests, pick a winner, load rf_* for the coming issue
//   ISSUE  | rf enable and gnt pulse active for exactly one cycle
//   RDWAIT | rf_data_out valid; captured into the winner's rdata
module reg16_8_arbiter #(
  parameter int DATA_W = jpu_rf_pkg::DATA_W,
  parameter int ADDR_W = jpu_rf_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  reg16_8_arbiter_if.slave  bus
);

  import jpu_rf_pkg::*;

  arb_state_t        state;
  logic [1:0]        win;
  logic              lat_idx;
  logic              lat_we;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .clock  (clock),
    .reset  (reset),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .update (state == ISSUE),
    .win    (win)
  );

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (win[1]) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // rf_addr/rf_data_in double as the latched address and write data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      lat_idx             <= REQ_IDX0;
      lat_we              <= 1'b0;
      bus.gnt0            <= 1'b0;
      bus.gnt1            <= 1'b0;
      bus.rvalid0         <= 1'b0;
      bus.rvalid1         <= 1'b0;
      bus.rdata0          <= '0;
      bus.rdata1          <= '0;
      bus.rf_enable_write <= 1'b0;
      bus.rf_enable_read  <= 1'b0;
      bus.rf_addr         <= '0;
      bus.rf_data_in      <= '0;
    end else begin
      bus.gnt0            <= 1'b0;
      bus.gnt1            <= 1'b0;
      bus.rvalid0         <= 1'b0;
      bus.rvalid1         <= 1'b0;
      bus.rf_enable_write <= 1'b0;
      bus.rf_enable_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (|win) begin
            lat_idx             <= win[1] ? REQ_IDX1 : REQ_IDX0;
            lat_we              <= sel_we;
            bus.rf_addr         <= sel_addr;
            bus.rf_data_in      <= sel_wdata;
            bus.rf_enable_write <= sel_we;
            bus.rf_enable_read  <= ~sel_we;
            bus.gnt0            <= win[0];
            bus.gnt1            <= win[1];
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          state <= lat_we ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (lat_idx == REQ_IDX1) begin
            bus.rdata1  <= bus.rf_data_out;
            bus.rvalid1 <= 1'b1;
          end else begin
            bus.rdata0  <= bus.rf_data_out;
            bus.rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg16_8_arbiter.md
Name: reg16_8_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-port 8x16 register file reg16_8 between the JPU operand-fetch stage (requester 0) and the writeback stage (requester 1). It serialises read and write operations onto reg16_8's one write-enable, one read-enable and one shared address port. It returns read data to the requester that issued the read. It sits between the pipeline stages and the reg16_8 instance.

Parameters:
DATA_W, 16, register width; must match reg16_8.
ADDR_W, 3, register address width (8 entries).

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-high reset.
req0  in  1  requester 0 operation request.
we0  in  1  1 = write, 0 = read (requester 0).
addr0  in  ADDR_W  register address (requester 0).
wdata0  in  DATA_W  write data (requester 0).
gnt0  out  1  one-cycle pulse: requester 0 operation issued to reg16_8.
rvalid0  out  1  one-cycle pulse: rdata0 holds read result.
rdata0  out  DATA_W  read result for requester 0.
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1.
rf_enable_write  out  1  to reg16_8 write enable.
rf_enable_read  out  1  to reg16_8 read enable.
rf_addr  out  ADDR_W  to reg16_8 rd_wr_addr.
rf_data_in  out  DATA_W  to reg16_8 data input.
rf_data_out  in  DATA_W  from reg16_8 read port; valid the cycle after rf_enable_read is high.

Behaviour:
- Reset (synchronous): state=IDLE; priority pointer=0 (requester 0 favoured). All outputs 0: gnt*, rvalid*, rdata*, rf_*.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: if req0|req1, pick the winner.
  - Only one requesting: that one wins.
  - Both requesting: the one named by the pointer wins.
  - Latch the winner's index, we, addr and wdata. Go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE (one cycle):
  - Drive rf_addr and rf_data_in from the latched fields.
  - Assert rf_enable_write if the latched we=1, else rf_enable_read.
  - Pulse gnt of the winner.
  - Flip the pointer to the other requester.
  - Next state: IDLE for a write, RDWAIT for a read.
- RDWAIT (one cycle):
  - rf_data_out is valid; register it into rdata of the winner at the end of this cycle.
  - Next state: IDLE.
  - rvalid of the winner pulses in the following cycle (the first IDLE cycle).
  - rdataN holds its value until the next read for that requester completes.
- Requester rule: hold reqN, weN, addrN and wdataN stable until gntN. Deassert req, or present a new operation, in the cycle after gnt.
  - A req still high in the IDLE cycle after gnt is treated as a new request.
  - A req dropped before gnt is legal; the arbiter samples only in IDLE.
- Timing, from req sampled in IDLE at cycle T:
  - Write: gnt and rf_enable_write at T+1; register updated at the T+1 edge.
  - Read: gnt and rf_enable_read at T+1, RDWAIT at T+2, rvalid at T+3.
  - Sustained throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- rf_enable_write and rf_enable_read are never both high, and are 0 outside ISSUE.
- rf_addr and rf_data_in hold their last values outside ISSUE.
- Ordering: operations complete in grant order. A read granted after a write to the same address returns the new data.
- The same requester can win consecutive arbitrations when the other is idle. The pointer still flips on every grant.
- Reset in any state, including ISSUE or RDWAIT:
  - Next cycle is IDLE with all outputs 0.
  - An in-flight read is dropped: no rvalid.
  - A write whose ISSUE cycle coincides with the reset edge is not guaranteed.
- No width arithmetic; addresses pass through unchanged. All 8 addresses are valid, with no wrap logic.

Decomposition:
- Shared package jpu_rf_pkg holds:
  - DATA_W=16 and ADDR_W=3 constants;
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RDWAIT=2'd2);
  - the requester index constants.
- One sub-module, rr_arb2: a 2-way round-robin pick with pointer register. It takes req0, req1 and an update strobe, and outputs a one-hot winner.

Test Plan:
- Reset held 3 cycles with req0=req1=1 -> all outputs 0 throughout; first gnt0 appears 2 cycles after reset falls.
- Req0 write addr 3'b001 data 16'hFF31, then req0 read addr 3'b001 -> rf_enable_write=1 with rf_addr=1 in ISSUE; read gives rvalid0 at T+3 with rdata0=16'hFF31; rvalid1 stays 0.
- req0 and req1 both held high with reads of addr 2 and addr 5 -> grants alternate gnt0, gnt1, gnt0…; each rvalid goes to the matching requester with the correct data.
- Same cycle: req0 writes addr 4 = 16'hA5A5 and req1 reads addr 4 (old value 16'h0000, pointer=0) -> write first, and rdata1=16'hA5A5. Repeat with pointer=1 -> rdata1 is the old value.
- Reset asserted during RDWAIT of a req1 read -> no rvalid1; rf_enable_read=0 next cycle; rdata1 = 0.
- Requester 1 writes 16'h1000+i to addresses 0..7 back-to-back, then reads all 8 -> each readback matches; exactly one gnt1 per operation; no cycle with both rf enables high.
